// File: rtl/adder_pipe_td.sv
// Pipelined adder with transport semantics: the sum is computed in stage 1,
// later stages only delay it, and a stalled output freezes the whole pipe.
module adder_pipe_td #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned LAT   = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           a,
    input  logic [WIDTH-1:0]           b,
    input  logic                       ci,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           sum,
    output logic                       co,
    output logic [$clog2(LAT+1)-1:0]   in_flight
);

    localparam int unsigned DW = WIDTH + 1;
    localparam int unsigned CW = $clog2(LAT + 1);

    logic           w_stall;
    logic           w_acc;
    logic           w_hs;
    logic [DW-1:0]  w_add;

    logic [LAT-1:0] r_valid;
    logic [DW-1:0]  r_data [LAT];
    logic [CW-1:0]  r_cnt;

    assign w_stall  = r_valid[LAT-1] && !out_ready;
    assign in_ready = !w_stall;
    assign w_acc    = in_valid && in_ready && !flush;
    assign w_hs     = r_valid[LAT-1] && out_ready;
    assign w_add    = DW'(a) + DW'(b) + DW'(ci);

    // Stage data is kept at zero whenever its valid bit is clear, so the
    // output stage directly provides sum/co = 0 while out_valid = 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int unsigned i = 0; i < LAT; i++) begin
                r_data[i] <= '0;
            end
        end else if (flush) begin
            r_valid <= '0;
            for (int unsigned i = 0; i < LAT; i++) begin
                r_data[i] <= '0;
            end
        end else if (!w_stall) begin
            r_valid[0] <= w_acc;
            r_data[0]  <= w_acc ? w_add : '0;
            for (int unsigned i = 1; i < LAT; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_data[i]  <= r_data[i-1];
            end
        end
    end

    // Occupancy counter; global stall means it can never exceed LAT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (flush) begin
            r_cnt <= '0;
        end else if (w_acc && !w_hs) begin
            r_cnt <= r_cnt + CW'(1);
        end else if (!w_acc && w_hs) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign out_valid = r_valid[LAT-1];
    assign sum       = r_data[LAT-1][WIDTH-1:0];
    assign co        = r_data[LAT-1][WIDTH];
    assign in_flight = r_cnt;

endmodule

// File: tb/tb_adder_pipe_td.sv
// Directed bench for adder_pipe_td: a WIDTH=4/LAT=3 instance for the main
// scenarios and a WIDTH=8/LAT=1 instance for the minimum-latency case.
module tb_adder_pipe_td;

    logic       clk;
    logic       rst_n;

    logic       in_valid, in_ready, flush, out_valid, out_ready, ci, co;
    logic [3:0] a, b, sum;
    logic [1:0] in_flight;

    logic       in_valid2, in_ready2, flush2, out_valid2, out_ready2, ci2, co2;
    logic [7:0] a2, b2, sum2;
    logic [0:0] in_flight2;

    int n_chk;
    int n_fail;

    adder_pipe_td #(.WIDTH(4), .LAT(3)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ci(ci), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .co(co), .in_flight(in_flight)
    );

    adder_pipe_td #(.WIDTH(8), .LAT(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .ci(ci2), .flush(flush2), .out_valid(out_valid2),
        .out_ready(out_ready2), .sum(sum2), .co(co2), .in_flight(in_flight2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [3:0] s, input logic c);
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(v));
        chk({tag, ".sum"}, 64'(sum), 64'(s));
        chk({tag, ".co"}, 64'(co), 64'(c));
    endtask

    initial begin
        logic [3:0] exp_s [5];
        logic       exp_c [5];
        logic [1:0] exp_f [8];
        n_chk = 0;
        n_fail = 0;
        rst_n = 1'b0;
        in_valid = 0; a = '0; b = '0; ci = 0; flush = 0; out_ready = 1;
        in_valid2 = 0; a2 = '0; b2 = '0; ci2 = 0; flush2 = 0; out_ready2 = 1;

        // Reset state
        #12;
        chk_out("reset", 1'b0, 4'd0, 1'b0);
        chk("reset.in_flight", 64'(in_flight), 64'd0);
        chk("reset.in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Single transaction 9+8+1 on the first edge after reset: 18 -> sum 2 co 1
        in_valid = 1; a = 4'd9; b = 4'd8; ci = 1;
        #1 chk("t1.in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 0;
        chk_out("t1.e0", 1'b0, 4'd0, 1'b0);
        chk("t1.e0.in_flight", 64'(in_flight), 64'd1);
        tick();
        chk_out("t1.e1", 1'b0, 4'd0, 1'b0);
        tick();
        chk_out("t1.e2", 1'b1, 4'd2, 1'b1);
        chk("t1.e2.in_flight", 64'(in_flight), 64'd1);
        tick();
        chk_out("t1.e3", 1'b0, 4'd0, 1'b0);
        chk("t1.e3.in_flight", 64'(in_flight), 64'd0);

        // Back-to-back a=i, b=15
        exp_s = '{4'd15, 4'd0, 4'd1, 4'd2, 4'd3};
        exp_c = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        exp_f = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
        for (int k = 0; k < 8; k++) begin
            in_valid = (k < 5);
            a = 4'(k); b = 4'd15; ci = 0;
            tick();
            chk($sformatf("t2.k%0d.in_flight", k), 64'(in_flight), 64'(exp_f[k]));
            if (k >= 2 && k <= 6)
                chk_out($sformatf("t2.k%0d", k), 1'b1, exp_s[k-2], exp_c[k-2]);
            else
                chk_out($sformatf("t2.k%0d", k), 1'b0, 4'd0, 1'b0);
        end
        in_valid = 0;

        // Fill with sums 4,5,6 then stall for 4 edges; offered set 7+2+1 must be refused
        out_ready = 0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1; a = 4'(k + 1); b = 4'd2; ci = 1;
            tick();
        end
        chk_out("t3.full", 1'b1, 4'd4, 1'b0);
        chk("t3.full.in_flight", 64'(in_flight), 64'd3);
        a = 4'd7;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t3.s%0d.in_ready", k), 64'(in_ready), 64'd0);
            tick();
            chk_out($sformatf("t3.s%0d", k), 1'b1, 4'd4, 1'b0);
            chk($sformatf("t3.s%0d.in_flight", k), 64'(in_flight), 64'd3);
        end
        in_valid = 0;
        out_ready = 1;
        #1 chk("t3.rel.in_ready", 64'(in_ready), 64'd1);
        tick();
        chk_out("t3.d0", 1'b1, 4'd5, 1'b0);
        chk("t3.d0.in_flight", 64'(in_flight), 64'd2);
        tick();
        chk_out("t3.d1", 1'b1, 4'd6, 1'b0);
        tick();
        chk_out("t3.d2", 1'b0, 4'd0, 1'b0);
        chk("t3.d2.in_flight", 64'(in_flight), 64'd0);

        // Flush with two in flight plus a concurrent offer
        for (int k = 0; k < 2; k++) begin
            in_valid = 1; a = 4'd3; b = 4'd3; ci = 0;
            tick();
        end
        flush = 1; a = 4'd1;
        #1 chk("t4.flush.in_ready", 64'(in_ready), 64'd1);
        tick();
        flush = 0; in_valid = 0;
        chk("t4.in_flight", 64'(in_flight), 64'd0);
        for (int k = 0; k < 5; k++) begin
            chk_out($sformatf("t4.k%0d", k), 1'b0, 4'd0, 1'b0);
            tick();
        end

        // Asynchronous reset pulse with results held at the output
        out_ready = 0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1; a = 4'd5; b = 4'd6; ci = 0;
            tick();
        end
        in_valid = 0;
        tick();
        chk_out("t5.pre", 1'b1, 4'd11, 1'b0);
        chk("t5.pre.in_flight", 64'(in_flight), 64'd2);
        #2 rst_n = 1'b0;
        #1;
        chk_out("t5.rst", 1'b0, 4'd0, 1'b0);
        chk("t5.rst.in_flight", 64'(in_flight), 64'd0);
        chk("t5.rst.in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk_out($sformatf("t5.k%0d", k), 1'b0, 4'd0, 1'b0);
        end

        // LAT=1, WIDTH=8: 255+255+1 = 511 -> sum 255 co 1; then 128+127+0 = 255 co 0
        in_valid2 = 1; a2 = 8'd255; b2 = 8'd255; ci2 = 1;
        tick();
        chk("t6.a.out_valid", 64'(out_valid2), 64'd1);
        chk("t6.a.sum", 64'(sum2), 64'd255);
        chk("t6.a.co", 64'(co2), 64'd1);
        chk("t6.a.in_flight", 64'(in_flight2), 64'd1);
        a2 = 8'd128; b2 = 8'd127; ci2 = 0;
        tick();
        in_valid2 = 0;
        chk("t6.b.sum", 64'(sum2), 64'd255);
        chk("t6.b.co", 64'(co2), 64'd0);
        chk("t6.b.in_flight", 64'(in_flight2), 64'd1);
        tick();
        chk("t6.c.out_valid", 64'(out_valid2), 64'd0);
        chk("t6.c.sum", 64'(sum2), 64'd0);
        chk("t6.c.in_flight", 64'(in_flight2), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
